id_fetch_ctrl: RTL and testbench

- Consumer end of the instruction-fetch interface; it sits between the fetch stage and the EX stage.
- Holds the IF/ID pipeline register with a valid bit.
- Decodes control-flow instructions (beq, bne, j, jal, jr) and resolves them in ID.
- Drives the stall, branch and jump_addr signals back to fetch, and flushes the wrong-path instruction.

---
 rtl/id_pkg.sv | 20 ++
 rtl/branch_resolve.sv | 52 +++++
 rtl/id_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_id_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode constants and types for the ID-stage fetch controller.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef logic [4:0] reg_idx_t;

  // Word offset of a conditional branch, sign-extended to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational decode of beq/bne/j/jal/jr: outcome, target and which
// source registers the control-flow instruction reads.
module branch_resolve
  import id_pkg::*;
(
  input  logic [31:0] inst_ID,
  input  logic [31:0] PC_ID,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] p4,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_ctrl
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_beq;
  logic       w_bne;
  logic       w_jmp;
  logic       w_jr;

  assign w_op    = inst_ID[31:26];
  assign w_funct = inst_ID[5:0];
  assign w_beq   = (w_op == OP_BEQ);
  assign w_bne   = (w_op == OP_BNE);
  assign w_jmp   = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_jr    = (w_op == OP_RTYPE) && (w_funct == FN_JR);

  assign p4      = PC_ID + 32'd4;
  assign uses_rs = w_beq | w_bne | w_jr;
  assign uses_rt = w_beq | w_bne;
  assign is_ctrl = w_beq | w_bne | w_jmp | w_jr;

  assign taken = (w_beq & (rs_data == rt_data))
               | (w_bne & (rs_data != rt_data))
               | w_jmp | w_jr;

  always_comb begin
    target = p4;
    if (w_beq | w_bne) begin
      target = p4 + br_offset(inst_ID[15:0]);
    end else if (w_jmp) begin
      target = {p4[31:28], inst_ID[25:0], 2'b00};
    end else if (w_jr) begin
      target = rs_data;
    end
  end

endmodule

// File: rtl/id_fetch_ctrl.sv
// IF/ID register, hazard detection and branch resolution in ID.
// Define DELAY_SLOT_EN to keep the instruction after a taken branch (delay slot).
module id_fetch_ctrl
  import id_pkg::*;
#(
  parameter logic [31:0] RST_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  input  logic [31:0] inst_IF,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic        stall,
  output logic        branch,
  output logic [31:0] jump_addr,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        issue_ID
);

  logic [31:0] r_pc_id;
  logic [31:0] r_inst_id;
  logic        r_valid_id;

  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_p4;
  logic        w_uses_rs;
  logic        w_uses_rt;
  logic        w_is_ctrl;
  reg_idx_t    w_rs;
  reg_idx_t    w_rt;
  logic        w_rs_src;
  logic        w_rt_src;
  logic        w_ctrl_rs;
  logic        w_ctrl_rt;
  logic        w_load_use;
  logic        w_ex_dep;
  logic        w_mem_dep;
  logic        w_taken_v;

  branch_resolve u_branch_resolve (
    .inst_ID (r_inst_id),
    .PC_ID   (r_pc_id),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .taken   (w_taken),
    .target  (w_target),
    .p4      (w_p4),
    .uses_rs (w_uses_rs),
    .uses_rt (w_uses_rt),
    .is_ctrl (w_is_ctrl)
  );

  assign w_rs = r_inst_id[25:21];
  assign w_rt = r_inst_id[20:16];

  // Ordinary instructions are assumed to read both fields; $0 never conflicts.
  assign w_rs_src  = (w_is_ctrl ? w_uses_rs : 1'b1) && (w_rs != 5'd0);
  assign w_rt_src  = (w_is_ctrl ? w_uses_rt : 1'b1) && (w_rt != 5'd0);
  assign w_ctrl_rs = w_uses_rs && (w_rs != 5'd0);
  assign w_ctrl_rt = w_uses_rt && (w_rt != 5'd0);

  assign w_load_use = ex_mem_read &&
                      ((w_rs_src && (ex_rd == w_rs)) || (w_rt_src && (ex_rd == w_rt)));
  assign w_ex_dep   = ex_reg_write &&
                      ((w_ctrl_rs && (ex_rd == w_rs)) || (w_ctrl_rt && (ex_rd == w_rt)));
  assign w_mem_dep  = mem_mem_read &&
                      ((w_ctrl_rs && (mem_rd == w_rs)) || (w_ctrl_rt && (mem_rd == w_rt)));

  assign stall     = r_valid_id && (w_load_use || w_ex_dep || w_mem_dep);
  assign w_taken_v = r_valid_id && w_taken;
  assign branch    = w_taken_v && !stall;
  assign jump_addr = w_taken_v ? w_target : w_p4;
  assign issue_ID  = r_valid_id && !stall;

  assign PC_ID   = r_pc_id;
  assign inst_ID = r_inst_id;
  assign rs_addr = w_rs;
  assign rt_addr = w_rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_id    <= RST_PC;
      r_inst_id  <= NOP_INST;
      r_valid_id <= 1'b0;
    end else if (!stall) begin
      r_pc_id <= PC_IF;
`ifdef DELAY_SLOT_EN
      r_inst_id  <= inst_IF;
      r_valid_id <= 1'b1;
`else
      if (branch) begin
        r_inst_id  <= NOP_INST;
        r_valid_id <= 1'b0;
      end else begin
        r_inst_id  <= inst_IF;
        r_valid_id <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// Self-checking bench for id_fetch_ctrl: vector table, multi-cycle sequences
// and randomized cycles against a spec-level model.
module tb_id_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF, inst_IF, rs_data, rt_data;
  logic        ex_reg_write, ex_mem_read, mem_mem_read;
  logic [4:0]  ex_rd, mem_rd;
  logic        stall, branch, issue_ID;
  logic [31:0] jump_addr, PC_ID, inst_ID;
  logic [4:0]  rs_addr, rt_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_fetch_ctrl dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF), .inst_IF(inst_IF),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .stall(stall), .branch(branch), .jump_addr(jump_addr),
    .PC_ID(PC_ID), .inst_ID(inst_ID), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .issue_ID(issue_ID)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_mem_read = 0; mem_rd = 0; rs_data = 0; rt_data = 0;
  endtask

  // Reset, then fetch one word so ID holds (pc, inst) with valid set.
  task automatic load_id(input logic [31:0] pc, input logic [31:0] inst);
    @(negedge clk); idle(); rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; PC_IF = pc; inst_IF = inst;
    @(posedge clk); @(negedge clk);
    PC_IF = pc + 32'd4; inst_IF = 32'h0;
  endtask

  typedef struct {
    logic [31:0] pc, inst, rs, rt;
    logic        ex_rw, ex_mr; logic [4:0] ex_rd;
    logic        mem_mr;       logic [4:0] mem_rd;
    logic        e_stall, e_branch; logic [31:0] e_jump;
  } vec_t;

  // ---------------- spec-level reference model ----------------
  typedef enum {K_BEQ, K_BNE, K_JUMP, K_JR, K_OTHER} kind_e;
  typedef struct { logic stall, branch; logic [31:0] jump; } exp_t;

  function automatic kind_e kind_of(input logic [31:0] w);
    case (w[31:26])
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02, 6'h03: return K_JUMP;
      6'h00: return (w[5:0] == 6'h08) ? K_JR : K_OTHER;
      default: return K_OTHER;
    endcase
  endfunction

  function automatic exp_t model_out(input logic v, input logic [31:0] pc, input logic [31:0] w,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic erw, input logic emr, input int erd,
                                     input logic mmr, input int mrd);
    exp_t e;
    kind_e k = kind_of(w);
    int srcs[$];
    int rs = int'(w[25:21]);
    int rt = int'(w[20:16]);
    logic hz = 0;
    logic tk = 0;
    logic [31:0] p4 = pc + 32'd4;
    logic [31:0] tg = p4;
    logic [15:0] imm = w[15:0];
    case (k)
      K_BEQ, K_BNE: begin srcs.push_back(rs); srcs.push_back(rt); end
      K_JR:         srcs.push_back(rs);
      K_JUMP:       ;
      default:      begin srcs.push_back(rs); srcs.push_back(rt); end
    endcase
    foreach (srcs[i]) begin
      if (srcs[i] != 0) begin
        if (emr && srcs[i] == erd) hz = 1;
        if (k != K_OTHER && ((erw && srcs[i] == erd) || (mmr && srcs[i] == mrd))) hz = 1;
      end
    end
    case (k)
      K_BEQ:  begin tk = (a == b); tg = p4 + 32'(signed'(imm)) * 4; end
      K_BNE:  begin tk = (a != b); tg = p4 + 32'(signed'(imm)) * 4; end
      K_JUMP: begin tk = 1; tg = (p4 & 32'hF000_0000) | (32'(w[25:0]) * 4); end
      K_JR:   begin tk = 1; tg = a; end
      default: ;
    endcase
    e.stall  = v && hz;
    e.branch = v && !hz && tk;
    e.jump   = (v && tk) ? tg : p4;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 6))
      0: return {6'h04, rs, rt, r[15:0]};
      1: return {6'h05, rs, rt, r[15:0]};
      2: return {6'h02, r[25:0]};
      3: return {6'h03, r[25:0]};
      4: return {6'h00, rs, 15'd0, 6'h08};
      5: return {6'h00, rs, rt, 5'd3, 5'd0, 6'h20};
      default: return r;
    endcase
  endfunction

  vec_t vecs[18];
  exp_t e;
  logic        m_valid, m_known;
  logic [31:0] m_pc, m_inst, exp_inst;
  logic        exp_issue;

  initial begin
    rst = 1; PC_IF = 0; inst_IF = 0; idle();

    //             pc            inst          rs            rt   erw emr erd mmr mrd  st br jump
    vecs[0]  = '{32'h10,       32'h10220003, 32'd5,        32'd5, 0, 0, 0,  0, 0,  0, 1, 32'h20};
    vecs[1]  = '{32'h10,       32'h14220003, 32'd7,        32'd7, 0, 0, 0,  0, 0,  0, 0, 32'h14};
    vecs[2]  = '{32'h10,       32'h14220003, 32'd7,        32'd8, 0, 0, 0,  0, 0,  0, 1, 32'h20};
    vecs[3]  = '{32'h10,       32'h1022FFFF, 32'd1,        32'd1, 0, 0, 0,  0, 0,  0, 1, 32'h10};
    vecs[4]  = '{32'hFFFFFFF8, 32'h10220004, 32'd9,        32'd9, 0, 0, 0,  0, 0,  0, 1, 32'h0C};
    vecs[5]  = '{32'hFFFFFFFC, 32'h03E00008, 32'h40,       32'd0, 0, 0, 0,  0, 0,  0, 1, 32'h40};
    vecs[6]  = '{32'hFFFFFFFC, 32'h08000010, 32'd0,        32'd0, 0, 0, 0,  0, 0,  0, 1, 32'h40};
    vecs[7]  = '{32'h40000000, 32'h0C000100, 32'd0,        32'd0, 0, 0, 0,  0, 0,  0, 1, 32'h40000400};
    vecs[8]  = '{32'h20,       32'h00441820, 32'd0,        32'd0, 0, 1, 2,  0, 0,  1, 0, 32'h24};
    vecs[9]  = '{32'h20,       32'h00441820, 32'd0,        32'd0, 0, 1, 4,  0, 0,  1, 0, 32'h24};
    vecs[10] = '{32'h20,       32'h00441820, 32'd0,        32'd0, 1, 0, 2,  0, 0,  0, 0, 32'h24};
    vecs[11] = '{32'h20,       32'h00441820, 32'd0,        32'd0, 0, 0, 0,  1, 2,  0, 0, 32'h24};
    vecs[12] = '{32'h10,       32'h10220003, 32'd1,        32'd2, 1, 0, 2,  0, 0,  1, 0, 32'h14};
    vecs[13] = '{32'h10,       32'h10220003, 32'd1,        32'd2, 0, 0, 0,  1, 1,  1, 0, 32'h14};
    vecs[14] = '{32'h100,      32'h03E00008, 32'h200,      32'd0, 1, 0, 31, 0, 0,  1, 0, 32'h200};
    vecs[15] = '{32'h100,      32'h0BE00010, 32'd0,        32'd0, 0, 1, 31, 0, 0,  0, 1, 32'h0F800040};
    vecs[16] = '{32'h30,       32'h00000000, 32'd0,        32'd0, 0, 1, 0,  0, 0,  0, 0, 32'h34};
    vecs[17] = '{32'h30,       32'h10000002, 32'd3,        32'd3, 1, 1, 0,  1, 0,  0, 1, 32'h3C};

    // ---------------- reset and first fetch ----------------
    @(negedge clk); rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; PC_IF = 0; inst_IF = 32'h00441820; idle();
    #1;
    $display("reset: PC_ID=%h inst_ID=%h issue=%b", PC_ID, inst_ID, issue_ID);
    chk("rst_pc", PC_ID, 32'h0);
    chk("rst_inst", inst_ID, 32'h0);
    chk("rst_issue", issue_ID, 0);
    chk("rst_stall", stall, 0);
    chk("rst_branch", branch, 0);
    @(posedge clk); @(negedge clk); #1;
    $display("first fetch: PC_ID=%h inst_ID=%h issue=%b", PC_ID, inst_ID, issue_ID);
    chk("first_inst", inst_ID, 32'h00441820);
    chk("first_issue", issue_ID, 1);

    // ---------------- table vectors ----------------
    foreach (vecs[i]) begin
      load_id(vecs[i].pc, vecs[i].inst);
      rs_data = vecs[i].rs; rt_data = vecs[i].rt;
      ex_reg_write = vecs[i].ex_rw; ex_mem_read = vecs[i].ex_mr; ex_rd = vecs[i].ex_rd;
      mem_mem_read = vecs[i].mem_mr; mem_rd = vecs[i].mem_rd;
      #1;
      $display("vec %0d pc=%h inst=%h stall=%b branch=%b jump=%h", i, PC_ID, inst_ID, stall, branch, jump_addr);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_branch", i), branch, vecs[i].e_branch);
      chk($sformatf("v%0d_jump", i), jump_addr, vecs[i].e_jump);
      chk($sformatf("v%0d_issue", i), issue_ID, !vecs[i].e_stall);
      chk($sformatf("v%0d_rs", i), rs_addr, vecs[i].inst[25:21]);
      chk($sformatf("v%0d_rt", i), rt_addr, vecs[i].inst[20:16]);
    end

    // ---------------- beq taken: wrong-path fetch handling ----------------
    load_id(32'h10, 32'h10220003);
    rs_data = 5; rt_data = 5; PC_IF = 32'h14; inst_IF = 32'hA8A5_0001;
    @(posedge clk); @(negedge clk); idle(); #1;
`ifdef DELAY_SLOT_EN
    exp_inst = 32'hA8A5_0001; exp_issue = 1;
`else
    exp_inst = 32'h0; exp_issue = 0;
`endif
    $display("beq squash: PC_ID=%h inst_ID=%h issue=%b", PC_ID, inst_ID, issue_ID);
    chk("sq_pc", PC_ID, 32'h14);
    chk("sq_inst", inst_ID, exp_inst);
    chk("sq_issue", issue_ID, exp_issue);
    chk("sq_branch", branch, 0);

    // ---------------- bne not taken: no bubble ----------------
    load_id(32'h10, 32'h14220003);
    rs_data = 7; rt_data = 7; PC_IF = 32'h14; inst_IF = 32'h00441820;
    #1; chk("bnt_branch", branch, 0);
    @(posedge clk); @(negedge clk); idle(); #1;
    $display("bne fallthrough: PC_ID=%h inst_ID=%h issue=%b", PC_ID, inst_ID, issue_ID);
    chk("bnt_pc", PC_ID, 32'h14);
    chk("bnt_inst", inst_ID, 32'h00441820);
    chk("bnt_issue", issue_ID, 1);

    // ---------------- load-use: one stall, PC_ID held ----------------
    load_id(32'h20, 32'h00441820);
    ex_mem_read = 1; ex_rd = 2; PC_IF = 32'h24; inst_IF = 32'h11111111;
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_issue", issue_ID, 0);
    @(posedge clk); @(negedge clk); ex_mem_read = 0; #1;
    $display("load-use release: PC_ID=%h stall=%b issue=%b", PC_ID, stall, issue_ID);
    chk("lu_pc_held", PC_ID, 32'h20);
    chk("lu_release", stall, 0);
    chk("lu_issue2", issue_ID, 1);

    // ---------------- load then dependent beq: two stalls ----------------
    load_id(32'h10, 32'h10220003);
    rs_data = 5; rt_data = 5; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2;
    #1;
    chk("lb_c1_stall", stall, 1);
    chk("lb_c1_branch", branch, 0);
    @(posedge clk); @(negedge clk);
    ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 1; mem_rd = 2; #1;
    chk("lb_c2_stall", stall, 1);
    chk("lb_c2_branch", branch, 0);
    chk("lb_c2_pc", PC_ID, 32'h10);
    @(posedge clk); @(negedge clk); mem_mem_read = 0; #1;
    $display("load-beq resolve: PC_ID=%h branch=%b jump=%h", PC_ID, branch, jump_addr);
    chk("lb_c3_stall", stall, 0);
    chk("lb_c3_branch", branch, 1);
    chk("lb_c3_jump", jump_addr, 32'h20);

    // ---------------- reset in the middle of a stall ----------------
    load_id(32'h20, 32'h00441820);
    ex_mem_read = 1; ex_rd = 2; #1;
    chk("rs_pre_stall", stall, 1);
    rst = 1;
    @(posedge clk); @(negedge clk); rst = 0; #1;
    $display("reset mid-stall: PC_ID=%h inst_ID=%h issue=%b", PC_ID, inst_ID, issue_ID);
    chk("rs_pc", PC_ID, 32'h0);
    chk("rs_inst", inst_ID, 32'h0);
    chk("rs_stall", stall, 0);
    chk("rs_issue", issue_ID, 0);

    // ---------------- randomized cycles vs model ----------------
    m_known = 0; m_valid = 0; m_pc = 0; m_inst = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 29) == 0);
      PC_IF = $urandom & 32'hFFFF_FFFC;
      inst_IF = rand_inst();
      rs_data = $urandom_range(0, 2);
      rt_data = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) rs_data = $urandom;
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_reg_write = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 3));
      mem_mem_read = ($urandom_range(0, 3) == 0);
      mem_rd = 5'($urandom_range(0, 3));
      #1;
      e = model_out(m_valid, m_pc, m_inst, rs_data, rt_data,
                    ex_reg_write, ex_mem_read, int'(ex_rd), mem_mem_read, int'(mem_rd));
      if (m_known) begin
        $display("rnd %0d pc=%h inst=%h stall=%b branch=%b jump=%h", i, PC_ID, inst_ID, stall, branch, jump_addr);
        chk("rnd_stall", stall, e.stall);
        chk("rnd_branch", branch, e.branch);
        chk("rnd_jump", jump_addr, e.jump);
        chk("rnd_issue", issue_ID, m_valid && !e.stall);
        chk("rnd_pc", PC_ID, m_pc);
        chk("rnd_inst", inst_ID, m_inst);
      end
      if (rst) begin
        m_pc = 32'h0; m_inst = 32'h0; m_valid = 0; m_known = 1;
      end else if (!e.stall) begin
        m_pc = PC_IF;
`ifdef DELAY_SLOT_EN
        m_inst = inst_IF; m_valid = 1;
`else
        if (e.branch) begin m_inst = 32'h0; m_valid = 0; end
        else begin m_inst = inst_IF; m_valid = 1; end
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
